irq_entry: RTL

- Core-side responder for the interrupt lines driven by the interrupt controller.
- Picks the highest-priority pending line and waits for an instruction boundary. It then saves the return PC, acknowledges the line, flushes the pipeline and redirects fetch to a per-source vector.
- Returns to the saved PC on mret.
- Sits in rtl/core between the interrupt controller and the fetch/EX control path.

---
 rtl/irq_entry_pkg.sv | 31 +++
 rtl/irq_entry_prio_enc.sv | 21 ++
 rtl/irq_entry.sv | 113 +++++++++++
 3 files changed

// File: rtl/irq_entry_pkg.sv
// Shared definitions for the interrupt entry/return sequencer.
package irq_entry_pkg;

  localparam int          IRQ_W_DEF      = 4;
  localparam int          ID_W_DEF       = 2;
  localparam logic [31:0] VEC_BASE_DEF   = 32'h0000_0100;
  localparam int          VEC_STRIDE_DEF = 4;

  typedef logic [IRQ_W_DEF-1:0] irq_bus;

  // Source ids; a lower id means a higher priority.
  localparam int IRQ_TIM     = 0;
  localparam int IRQ_UART_TX = 1;
  localparam int IRQ_UART_RX = 2;
  localparam int IRQ_FFT     = 3;

  // Sequencer state encodings
  localparam logic [2:0] ST_IDLE  = 3'd0;
  localparam logic [2:0] ST_WAIT  = 3'd1;
  localparam logic [2:0] ST_ENTER = 3'd2;
  localparam logic [2:0] ST_ISR   = 3'd3;
  localparam logic [2:0] ST_RET   = 3'd4;

  // Vector address for a source: 32-bit wrap-around, no overflow check
  function automatic logic [31:0] vec_addr(input logic [31:0] base,
                                           input logic [31:0] id,
                                           input int          stride);
    return base + id * 32'(stride);
  endfunction

endpackage

// File: rtl/irq_entry_prio_enc.sv
// Lowest-index-first priority encoder for the interrupt lines.
module irq_prio_enc #(
  parameter int IRQ_W = 4,
  parameter int ID_W  = 2
) (
  input  logic [IRQ_W-1:0] irq_i,
  output logic [ID_W-1:0]  id_o,
  output logic             vld_o
);

  // Scan from the top down so the lowest set index is written last and wins
  always_comb begin
    id_o = '0;
    for (int i = IRQ_W - 1; i >= 0; i--) begin
      if (irq_i[i]) id_o = ID_W'(i);
    end
  end

  assign vld_o = |irq_i;

endmodule

// File: rtl/irq_entry.sv
// Interrupt entry/return sequencer: waits for an instruction boundary,
// saves the return PC, acks the source and redirects fetch to its vector;
// on mret it redirects back to the saved PC.
module irq_entry
  import irq_entry_pkg::*;
#(
  parameter int          IRQ_W      = IRQ_W_DEF,
  parameter int          ID_W       = ID_W_DEF,
  parameter logic [31:0] VEC_BASE   = VEC_BASE_DEF,
  parameter int          VEC_STRIDE = VEC_STRIDE_DEF
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic [IRQ_W-1:0] irq_i,
  output logic             irq_ack,
  output logic [ID_W-1:0]  irq_id_o,
  input  logic             global_ie_i,
  input  logic [31:0]      pc_i,
  input  logic             boundary_i,
  input  logic             mret_i,
  output logic             hold_o,
  output logic             jump_o,
  output logic [31:0]      jump_addr_o,
  output logic             flush_o,
  output logic [31:0]      epc_o,
  output logic [ID_W-1:0]  cause_o,
  output logic             in_isr_o
);

  logic [2:0]      state_q, state_d;
  logic [ID_W-1:0] cause_q, cause_d;
  logic [31:0]     epc_q, epc_d;
  logic            in_isr_q, in_isr_d;
  logic [ID_W-1:0] enc_id;
  logic            enc_vld;

  irq_prio_enc #(
    .IRQ_W (IRQ_W),
    .ID_W  (ID_W)
  ) u_prio_enc (
    .irq_i (irq_i),
    .id_o  (enc_id),
    .vld_o (enc_vld)
  );

  // Next-state logic. RET behaves like an IDLE cycle for recognition so a
  // pending line is acked two cycles after the return redirect.
  always_comb begin
    state_d  = state_q;
    cause_d  = cause_q;
    epc_d    = epc_q;
    in_isr_d = in_isr_q;
    case (state_q)
      ST_IDLE, ST_RET: begin
        if (state_q == ST_RET) in_isr_d = 1'b0;
        if (global_ie_i && enc_vld) begin
          cause_d = enc_id;
          state_d = ST_WAIT;
        end else begin
          state_d = ST_IDLE;
        end
      end
      ST_WAIT: begin
        if (!enc_vld || !global_ie_i) begin
          state_d = ST_IDLE;
        end else begin
          // re-encode every cycle so a higher-priority arrival takes over
          cause_d = enc_id;
          if (boundary_i) begin
            epc_d   = pc_i;
            state_d = ST_ENTER;
          end
        end
      end
      ST_ENTER: begin
        in_isr_d = 1'b1;
        state_d  = ST_ISR;
      end
      ST_ISR: begin
        if (mret_i) state_d = ST_RET;
      end
      default: state_d = ST_IDLE;
    endcase
  end

  // State and saved-context registers
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q  <= ST_IDLE;
      cause_q  <= '0;
      epc_q    <= '0;
      in_isr_q <= 1'b0;
    end else begin
      state_q  <= state_d;
      cause_q  <= cause_d;
      epc_q    <= epc_d;
      in_isr_q <= in_isr_d;
    end
  end

  // Moore outputs decoded from state; all clear when reset forces IDLE
  assign irq_ack     = (state_q == ST_ENTER);
  assign irq_id_o    = (state_q == ST_ENTER) ? cause_q : '0;
  assign hold_o      = (state_q == ST_WAIT) || (state_q == ST_ENTER);
  assign jump_o      = (state_q == ST_ENTER) || (state_q == ST_RET);
  assign flush_o     = jump_o;
  assign jump_addr_o = (state_q == ST_ENTER) ? vec_addr(VEC_BASE, 32'(cause_q), VEC_STRIDE) :
                       (state_q == ST_RET)   ? epc_q : 32'h0;
  assign epc_o       = epc_q;
  assign cause_o     = cause_q;
  assign in_isr_o    = in_isr_q;

endmodule
